// File: rtl/timer_prescaler_pkg.sv
// ---------------------------------------------------------------------------
// timer_prescaler_pkg
// Shared definitions for the timer clock-enable prescaler:
//   - CKS divisor-select encodings (/2, /4, /8, /16)
//   - default width of the prescale counter
//   - the per-edge action enum used by the prescaler's next-state logic
//   - divisorOf(): divide ratio N for a CKS code, used by benches and status
// ---------------------------------------------------------------------------
package timer_prescaler_pkg;

   // Default prescale counter width; 4 bits is the minimum that reaches /16.
   localparam int PSC_W_DEFAULT = 4;

   // Divisor select encodings as seen on the cks input.
   localparam logic [1:0] CKS_DIV2  = 2'b00;
   localparam logic [1:0] CKS_DIV4  = 2'b01;
   localparam logic [1:0] CKS_DIV8  = 2'b10;
   localparam logic [1:0] CKS_DIV16 = 2'b11;

   // What the prescaler does on a given rising edge, highest priority first:
   // an explicit clear, a restart caused by a divisor change, a hold while
   // disabled, or a normal count step.
   typedef enum logic [1:0] {
      PSC_CLEAR   = 2'd0,
      PSC_RESTART = 2'd1,
      PSC_HOLD    = 2'd2,
      PSC_COUNT   = 2'd3
   } pscAction_e;

   // Divide ratio N = 2^(cks + 1) for a divisor select code.
   function automatic int divisorOf(input logic [1:0] cksSel);
      return 2 << cksSel;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// ---------------------------------------------------------------------------
// timer_prescaler
// Clock-enable generator feeding the 8-bit timer counter. Divides clk by
// 2, 4, 8 or 16 and emits a registered, single-cycle clk_ena pulse once per
// selected period. Supports enable gating (phase is frozen while disabled),
// a synchronous clear strobe, and glitch-free divisor change (a change of
// cks restarts the period so no pulse is lost or doubled).
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   enable   in   1 = count, 0 = hold counter and force clk_ena low
//   cks      in   divisor select (00=/2, 01=/4, 10=/8, 11=/16)
//   psc_clr  in   synchronous clear strobe for the prescale counter
//   clk_ena  out  one-clk-wide enable pulse to the timer counter
//   psc_cnt  out  current prescale counter value (status/debug)
// ---------------------------------------------------------------------------
module timer_prescaler
   import timer_prescaler_pkg::*;
#(
   parameter int PSC_W = PSC_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [1:0]       cks,
   input  logic             psc_clr,
   output logic             clk_ena,
   output logic [PSC_W-1:0] psc_cnt
);

   logic [PSC_W-1:0] pscCnt_q;
   logic [PSC_W-1:0] pscCnt_d;
   logic             clkEna_q;
   logic             clkEna_d;
   logic [1:0]       cks_q;
   logic [1:0]       cks_d;

   logic [PSC_W-1:0] phaseMask;
   logic             phaseTerminal;
   pscAction_e       action;

   // Build a mask covering psc_cnt[k:0] with k = cks_q. The period of the
   // pulse is set by how many low bits must all be ones, so the same free
   // running counter serves every divisor and simply wraps at 2^PSC_W.
   always_comb begin
      phaseMask = '0;
      for (int i = 0; i < PSC_W; i++) begin
         if (i <= int'(cks_q)) begin
            phaseMask[i] = 1'b1;
         end
      end
   end

   // The current edge closes a period when every masked bit is one.
   always_comb begin
      phaseTerminal = ((pscCnt_q & phaseMask) == phaseMask);
   end

   // Decide what this edge does. A clear beats a divisor change, which beats
   // the enable hold; comparing cks against its registered copy is what
   // detects a divisor change.
   always_comb begin
      action = PSC_COUNT;
      if (psc_clr) begin
         action = PSC_CLEAR;
      end else if (cks != cks_q) begin
         action = PSC_RESTART;
      end else if (!enable) begin
         action = PSC_HOLD;
      end
   end

   // Next-state logic. Clear and restart behave identically: the counter
   // starts a fresh period under the newly latched divisor, so the first
   // pulse after a change lands exactly N_new edges later. clk_ena defaults
   // low, which is what guarantees it can never stay high for two cycles:
   // after a pulse the low bits are all zero again.
   always_comb begin
      pscCnt_d = pscCnt_q;
      clkEna_d = 1'b0;
      cks_d    = cks_q;
      case (action)
         PSC_CLEAR, PSC_RESTART: begin
            pscCnt_d = '0;
            cks_d    = cks;
         end
         PSC_HOLD: begin
            pscCnt_d = pscCnt_q;
         end
         PSC_COUNT: begin
            clkEna_d = phaseTerminal;
            pscCnt_d = pscCnt_q + PSC_W'(1);
         end
         default: begin
            pscCnt_d = pscCnt_q;
         end
      endcase
   end

   // State registers. Reset is asynchronous so a pulse in flight is killed
   // immediately, and cks_q returns to the /2 encoding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pscCnt_q <= '0;
         clkEna_q <= 1'b0;
         cks_q    <= CKS_DIV2;
      end else begin
         pscCnt_q <= pscCnt_d;
         clkEna_q <= clkEna_d;
         cks_q    <= cks_d;
      end
   end

   assign clk_ena = clkEna_q;
   assign psc_cnt = pscCnt_q;

endmodule

// File: tb/tb_timer_prescaler.sv
// ---------------------------------------------------------------------------
// tb_timer_prescaler
// Self-checking bench for timer_prescaler. A behavioural model tracks the
// prescaler as "position within the current period" using plain modulo
// arithmetic and checks clk_ena / psc_cnt after every edge. Directed steps
// additionally measure pulse distances in edges against fixed expectations,
// followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_timer_prescaler;
   import timer_prescaler_pkg::*;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b1;
   logic       enable  = 1'b0;
   logic [1:0] cks     = 2'b00;
   logic       psc_clr = 1'b0;
   logic       clk_ena;
   logic [3:0] psc_cnt;

   int assertCount = 0;
   int failCount   = 0;

   // Reference model state: count of enabled edges in the running period
   // (wrapping like a 4-bit counter), latched divisor and expected pulse.
   int         mCnt    = 0;
   logic [1:0] mCks    = 2'b00;
   logic       mEna    = 1'b0;
   logic       prevEna = 1'b0;

   int edges;
   int pulses;
   logic [1:0] curCks;

   timer_prescaler #(.PSC_W(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .cks     (cks),
      .psc_clr (psc_clr),
      .clk_ena (clk_ena),
      .psc_cnt (psc_cnt)
   );

   always #5 clk = ~clk;

   // Compare DUT outputs against the model, and make sure no two consecutive
   // observed cycles both carry a pulse.
   task automatic checkOutput(input string tag);
      assertCount++;
      assert (clk_ena === mEna) else begin
         failCount++;
         $error("[TB] FAIL %s clk_ena: observed %b expected %b", tag, clk_ena, mEna);
      end
      assertCount++;
      assert (psc_cnt === 4'(mCnt)) else begin
         failCount++;
         $error("[TB] FAIL %s psc_cnt: observed %0d expected %0d", tag, psc_cnt, mCnt);
      end
      assertCount++;
      assert ((prevEna & clk_ena) === 1'b0) else begin
         failCount++;
         $error("[TB] FAIL %s double_pulse: observed %b%b expected no back-to-back", tag, prevEna, clk_ena);
      end
      prevEna = clk_ena;
   endtask

   // Drive one cycle of inputs, advance the model by one edge, then check.
   task automatic applyStimulus(input logic en, input logic [1:0] c, input logic clr, input string tag);
      int n;
      enable  = en;
      cks     = c;
      psc_clr = clr;
      @(posedge clk);
      n = divisorOf(mCks);
      if (clr || (c != mCks)) begin
         mCnt = 0;
         mEna = 1'b0;
         mCks = c;
      end else if (!en) begin
         mEna = 1'b0;
      end else begin
         mEna = ((mCnt % n) == (n - 1));
         mCnt = (mCnt + 1) % 16;
      end
      #1;
      checkOutput(tag);
   endtask

   // Apply reset asynchronously between edges, check the outputs clear at
   // once and stay clear across an edge, then release away from an edge.
   task automatic resetAsync(input string tag);
      #1;
      rst_n = 1'b0;
      mCnt  = 0;
      mCks  = 2'b00;
      mEna  = 1'b0;
      #1;
      checkOutput({tag, "_immediate"});
      @(posedge clk);
      #1;
      checkOutput({tag, "_held"});
      @(negedge clk);
      rst_n = 1'b1;
      prevEna = 1'b0;
   endtask

   // Run edges with fixed inputs until a pulse shows up; -1 if none within limit.
   task automatic edgesToPulse(input logic en, input logic [1:0] c, input int limit,
                               input string tag, output int count);
      count = -1;
      for (int i = 1; i <= limit; i++) begin
         applyStimulus(en, c, 1'b0, tag);
         if (clk_ena === 1'b1) begin
            count = i;
            break;
         end
      end
   endtask

   task automatic checkValue(input string tag, input int observed, input int expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Advance (enabled, fixed cks) until psc_cnt reaches a target, bounded.
   task automatic runToCount(input logic [1:0] c, input int target, input string tag);
      for (int i = 0; i < 20 && psc_cnt != 4'(target); i++) begin
         applyStimulus(1'b1, c, 1'b0, tag);
      end
      checkValue({tag, "_reached"}, int'(psc_cnt), target);
   endtask

   initial begin
      $display("[TB] timer_prescaler bench start");

      // Reset state, then /2: pulses on every even edge after release.
      resetAsync("reset");
      pulses = 0;
      for (int i = 1; i <= 40; i++) begin
         applyStimulus(1'b1, CKS_DIV2, 1'b0, "div2_run");
         checkValue("div2_even_edge", int'(clk_ena), (i % 2 == 0) ? 1 : 0);
         if (clk_ena === 1'b1) pulses++;
      end
      checkValue("div2_pulse_count", pulses, 20);

      // /16 from reset: reset leaves the /2 code latched, so edge 1 latches
      // /16 and starts the period; the pulse lands 16 edges later (edge 17)
      // together with the counter wrapping to 0.
      resetAsync("reset16");
      edgesToPulse(1'b1, CKS_DIV16, 40, "div16_first", edges);
      checkValue("div16_first_edge", edges, 17);
      checkValue("div16_wrap_cnt", int'(psc_cnt), 0);
      edgesToPulse(1'b1, CKS_DIV16, 40, "div16_second", edges);
      checkValue("div16_period", edges, 16);

      // /8 with a 5-cycle hold at psc_cnt = 3: phase is preserved.
      applyStimulus(1'b1, CKS_DIV8, 1'b0, "div8_latch");
      runToCount(CKS_DIV8, 3, "div8_to3");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, CKS_DIV8, 1'b0, "div8_hold");
         checkValue("div8_hold_nopulse", int'(clk_ena), 0);
         checkValue("div8_hold_frozen", int'(psc_cnt), 3);
      end
      edgesToPulse(1'b1, CKS_DIV8, 20, "div8_resume", edges);
      checkValue("div8_resume_edges", edges, 5);

      // Divisor change /2 -> /16 mid-period.
      applyStimulus(1'b1, CKS_DIV2, 1'b0, "chg_latch2");
      applyStimulus(1'b1, CKS_DIV2, 1'b0, "chg_mid");
      applyStimulus(1'b1, CKS_DIV16, 1'b0, "chg_latch16");
      checkValue("chg_restart_cnt", int'(psc_cnt), 0);
      edgesToPulse(1'b1, CKS_DIV16, 40, "chg_first", edges);
      checkValue("chg_first_edges", edges, 16);
      edgesToPulse(1'b1, CKS_DIV16, 40, "chg_second", edges);
      checkValue("chg_period", edges, 16);

      // Clear at psc_cnt = 6 under /16, then clear while disabled.
      runToCount(CKS_DIV16, 6, "clr_to6");
      applyStimulus(1'b1, CKS_DIV16, 1'b1, "clr_strobe");
      checkValue("clr_cnt_zero", int'(psc_cnt), 0);
      edgesToPulse(1'b1, CKS_DIV16, 40, "clr_next", edges);
      checkValue("clr_next_edges", edges, 16);
      runToCount(CKS_DIV16, 4, "clrdis_to4");
      applyStimulus(1'b0, CKS_DIV16, 1'b1, "clr_disabled");
      checkValue("clr_disabled_cnt", int'(psc_cnt), 0);

      // Async reset while a /8 pulse is on the output, then /8 from release.
      edgesToPulse(1'b1, CKS_DIV8, 40, "rst_pulse", edges);
      checkValue("rst_pulse_seen", int'(clk_ena), 1);
      resetAsync("rst_mid");
      edgesToPulse(1'b1, CKS_DIV8, 40, "rst_after", edges);
      checkValue("rst_after_edges", edges, 9);

      // Randomized run: mostly enabled, occasional divisor changes and clears.
      curCks = CKS_DIV4;
      pulses = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 24) == 0) curCks = 2'($urandom_range(0, 3));
         applyStimulus(($urandom_range(0, 7) != 0), curCks,
                       ($urandom_range(0, 39) == 0), "random");
         if (clk_ena === 1'b1) pulses++;
      end
      $display("[TB] random phase produced %0d pulses", pulses);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
